ks_sum_stage: RTL and testbench

// - Final stage of the 28-bit Kogge-Stone adder, directly downstream of the last prefix layer.
// - Consumes the half-sum propagate vector and the final group-generate (carry) vector; forms sum, carry-out and signed overflow.
// - Registers results behind a valid/ready handshake with a 2-entry skid buffer, so the combinational prefix tree can feed a pipelined FP datapath.

---
 rtl/ks_pkg.sv | 22 ++
 rtl/ks_skid_buf.sv | 94 +++++++++
 rtl/ks_sum_stage.sv | 79 +++++++
 tb/tb_ks_sum_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// ks_pkg -- shared types for the Kogge-Stone adder final sum stage.
//   KS_WIDTH   : adder operand width
//   ks_res_t   : result payload carried through the skid buffer
//   sb_state_e : skid buffer occupancy states
package ks_pkg;

  localparam int KS_WIDTH = 28;

  typedef struct packed {
    logic [KS_WIDTH-1:0] sum;
    logic                cout;
    logic                ovf;
    logic                zero;
  } ks_res_t;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_BUSY  = 2'd1,
    SB_FULL  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/ks_skid_buf.sv
// ks_skid_buf -- 2-entry valid/ready skid buffer carrying a ks_res_t.
// The main register drives out_data directly; the skid register catches the
// one item accepted while the downstream is stalled, so in_ready can be a
// pure register output with no path from out_ready.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : upstream handshake (in_ready registered)
//   in_data              : payload presented by upstream
//   out_valid / out_ready: downstream handshake
//   out_data             : payload held in the main register
//
// state    | meaning
// ---------+------------------------------------------------------------
// SB_EMPTY | nothing stored; in_ready=1, out_valid=0
// SB_BUSY  | main holds one item; in_ready=1, out_valid=1
// SB_FULL  | main and skid both hold items; in_ready=0, out_valid=1
module ks_skid_buf
  import ks_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    in_valid,
  output logic    in_ready,
  input  ks_res_t in_data,
  output logic    out_valid,
  input  logic    out_ready,
  output ks_res_t out_data
);

  sb_state_e state_q, state_d;
  ks_res_t   main_q, main_d;
  ks_res_t   skid_q, skid_d;
  logic      in_ready_q;
  logic      accept;
  logic      drain;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != SB_EMPTY);
  assign out_data  = main_q;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      SB_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = SB_BUSY;
        end
      end
      SB_BUSY: begin
        if (accept && drain) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = SB_FULL;
        end else if (drain) begin
          state_d = SB_EMPTY;
        end
      end
      SB_FULL: begin
        // in_ready is low here, so no new item can arrive alongside the drain
        if (drain) begin
          main_d  = skid_q;
          state_d = SB_BUSY;
        end
      end
      default: begin
        state_d = SB_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SB_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      // registered copy of "next state is not FULL"
      in_ready_q <= (state_d != SB_FULL);
    end
  end

endmodule

// File: rtl/ks_sum_stage.sv
// ks_sum_stage -- final stage of the 28-bit Kogge-Stone adder.
// Forms sum, carry-out and signed overflow from the half-sum propagate vector
// and the final group-generate vector, then registers the result behind a
// valid/ready handshake with a 2-entry skid buffer (1-cycle latency).
//
// Optional feature macro: KS_SUM_ZERO_EN
//   defined   : out_zero = (sum == 0), computed in the input cycle and carried
//               with the sum through the buffer
//   undefined : no zero-detect; out_zero is constant 0
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream handshake
//   in_hp [WIDTH]       : half-sum propagate, a^b
//   in_g  [WIDTH]       : group generate, g[i] = carry out of bit i (cin folded in)
//   in_cin              : adder carry-in
//   out_valid/out_ready : downstream handshake
//   out_sum [WIDTH]     : sum
//   out_cout            : carry out
//   out_ovf             : signed overflow
//   out_zero            : sum is zero (see macro above)
module ks_sum_stage
  import ks_pkg::*;
#(
  // must match ks_pkg::KS_WIDTH, which sizes the buffered payload
  parameter int WIDTH = KS_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_hp,
  input  logic [WIDTH-1:0] in_g,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  logic [WIDTH-1:0] sum;
  ks_res_t          res;
  ks_res_t          out_res;

  // carry into bit i is g[i-1]; carry into bit 0 is cin
  assign sum = in_hp ^ {in_g[WIDTH-2:0], in_cin};

  always_comb begin
    res      = '0;
    res.sum  = sum;
    res.cout = in_g[WIDTH-1];
    // carry into MSB differs from carry out of MSB
    res.ovf  = in_g[WIDTH-1] ^ in_g[WIDTH-2];
`ifdef KS_SUM_ZERO_EN
    res.zero = ~|sum;
`else
    res.zero = 1'b0;
`endif
  end

  ks_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_res)
  );

  assign out_sum  = out_res.sum;
  assign out_cout = out_res.cout;
  assign out_ovf  = out_res.ovf;
  assign out_zero = out_res.zero;

endmodule

// File: tb/tb_ks_sum_stage.sv
module tb_ks_sum_stage;

  localparam int W = 28;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_hp;
  logic [W-1:0] in_g;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  int n_checks = 0;
  int n_fail   = 0;

  ks_sum_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_hp     (in_hp),
    .in_g      (in_g),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // carry out of each bit position, from plain integer addition of the low bits
  function automatic logic [W-1:0] gen_g(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    logic [W:0]   t;
    logic [W:0]   m;
    logic [W-1:0] g;
    g = '0;
    for (int i = 0; i < W; i++) begin
      m = ((W+1)'(1) << (i + 1)) - (W+1)'(1);
      t = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, c};
      g[i] = t[i+1];
    end
    return g;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c);
    logic [W:0] s;
    exp_t e;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.sum  = s[W-1:0];
    e.cout = s[W];
    e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
`ifdef KS_SUM_ZERO_EN
    e.zero = (s[W-1:0] == '0);
`else
    e.zero = 1'b0;
`endif
    return e;
  endfunction

  // Drive one cycle: inputs change at negedge, handshake/outputs sampled 1 time
  // unit later (before the posedge that performs the transfer), then the task
  // returns right after that posedge.
  task automatic drive_cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input logic ordy,
                             output logic acc, output logic drn, output logic ov,
                             output exp_t got);
    @(negedge clk);
    in_valid  = v;
    in_hp     = a ^ b;
    in_g      = gen_g(a, b, c);
    in_cin    = c;
    out_ready = ordy;
    #1;
    acc = in_valid & in_ready;
    drn = out_valid & out_ready;
    ov  = out_valid;
    got = {out_sum, out_cout, out_ovf, out_zero};
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_hp = '0; in_g = '0; in_cin = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b zero=%b, expected all 0",
               out_valid, out_sum, out_cout, out_ovf, out_zero);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    logic acc, drn, ov;
    exp_t got, e, now;
    va[0] = 28'hFFFFFFF; vb[0] = 28'h0000001; vc[0] = 1'b0;
    va[1] = 28'h7FFFFFF; vb[1] = 28'h0000001; vc[1] = 1'b0;
    va[2] = 28'h0000000; vb[2] = 28'h0000000; vc[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = model(va[k], vb[k], vc[k]);
      drive_cycle(1'b1, va[k], vb[k], vc[k], 1'b1, acc, drn, ov, got);
      n_checks++;
      if (ov !== 1'b0 || acc !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_accept[%0d]: got out_valid=%b accept=%b, expected 0/1", k, ov, acc);
      end
      #1;
      now = {out_sum, out_cout, out_ovf, out_zero};
      n_checks++;
      if (out_valid !== 1'b1 || now !== e) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got valid=%b res=%h, expected valid=1 res=%h",
                 k, out_valid, now, e);
      end
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, ov, got);
      #1;
      n_checks++;
      if (drn !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_drain[%0d]: got drain=%b valid_after=%b, expected 1/0", k, drn, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] ia [3];
    logic [W-1:0] ib [3];
    logic         ic [3];
    exp_t q[$];
    exp_t first, got, e;
    logic acc, drn, ov;
    int idx, ndrained;
    for (int k = 0; k < 3; k++) begin
      ia[k] = W'($urandom); ib[k] = W'($urandom); ic[k] = 1'($urandom);
    end
    first = model(ia[0], ib[0], ic[0]);
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, ia[idx], ib[idx], ic[idx], 1'b0, acc, drn, ov, got);
      if (acc) begin
        q.push_back(model(ia[idx], ib[idx], ic[idx]));
        idx++;
      end
      if (k >= 1) begin
        n_checks++;
        if (ov !== 1'b1 || got !== first) begin
          n_fail++;
          $display("FAIL stall_frozen[%0d]: got valid=%b res=%h, expected valid=1 res=%h",
                   k, ov, got, first);
        end
      end
    end
    #1;
    n_checks++;
    if (idx != 2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_full: got accepted=%0d in_ready=%b, expected 2/0", idx, in_ready);
    end
    ndrained = 0;
    for (int cyc = 0; cyc < 12 && ndrained < 3; cyc++) begin
      if (idx < 3)
        drive_cycle(1'b1, ia[idx], ib[idx], ic[idx], 1'b1, acc, drn, ov, got);
      else
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, ov, got);
      if (drn) begin
        e = (q.size() > 0) ? q.pop_front() : '0;
        ndrained++;
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL stall_order[%0d]: got %h expected %h", ndrained, got, e);
        end
      end
      if (acc) begin
        q.push_back(model(ia[idx], ib[idx], ic[idx]));
        idx++;
      end
    end
    n_checks++;
    if (ndrained != 3) begin
      n_fail++;
      $display("FAIL stall_drain_count: got %0d expected 3", ndrained);
    end
  endtask

  task automatic test_stream();
    exp_t q[$];
    exp_t got, e;
    logic acc, drn, ov;
    logic [W-1:0] a, b;
    logic c;
    int n, nout;
    n = 0; nout = 0;
    for (int cyc = 0; cyc < 1010 && n < 1000; cyc++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      drive_cycle(1'b1, a, b, c, 1'b1, acc, drn, ov, got);
      if (drn) begin
        e = (q.size() > 0) ? q.pop_front() : '0;
        nout++;
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL stream_data[%0d]: got %h expected %h", nout, got, e);
        end
      end
      n_checks++;
      if (acc !== 1'b1 || (cyc > 0 && drn !== 1'b1)) begin
        n_fail++;
        $display("FAIL stream_rate[%0d]: got accept=%b drain=%b, expected 1/1", cyc, acc, drn);
      end
      if (acc) begin
        q.push_back(model(a, b, c));
        n++;
      end
    end
    for (int cyc = 0; cyc < 4 && q.size() > 0; cyc++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, ov, got);
      if (drn) begin
        e = q.pop_front();
        nout++;
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL stream_tail: got %h expected %h", got, e);
        end
      end
    end
    n_checks++;
    if (nout != 1000) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results expected 1000", nout);
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t got, e;
    logic acc, drn, ov;
    logic [W-1:0] a, b;
    logic c, v, ordy;
    int nin, nout;
    nin = 0; nout = 0;
    a = W'($urandom); b = W'($urandom); c = 1'($urandom); v = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      ordy = ($urandom_range(0, 2) != 0);
      drive_cycle(v, a, b, c, ordy, acc, drn, ov, got);
      if (drn) begin
        e = (q.size() > 0) ? q.pop_front() : '0;
        nout++;
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL b2b_data[%0d]: got %h expected %h", nout, got, e);
        end
      end
      if (acc) begin
        q.push_back(model(a, b, c));
        nin++;
      end
      // upstream holds the same item until it is accepted
      if (acc || !v) begin
        a = W'($urandom); b = W'($urandom); c = 1'($urandom);
        v = ($urandom_range(0, 3) != 0);
      end
    end
    for (int cyc = 0; cyc < 6 && q.size() > 0; cyc++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, ov, got);
      if (drn) begin
        e = q.pop_front();
        nout++;
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL b2b_tail: got %h expected %h", got, e);
        end
      end
    end
    n_checks++;
    if (nout != nin || q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d out for %0d in, expected equal", nout, nin);
    end
  endtask

  task automatic test_reset_mid();
    exp_t got, e;
    logic acc, drn, ov;
    logic [W-1:0] a, b;
    logic c;
    for (int k = 0; k < 2; k++)
      drive_cycle(1'b1, W'($urandom) | 28'h1, W'($urandom), 1'b1, 1'b0, acc, drn, ov, got);
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_full: got in_ready=%b out_valid=%b, expected 0/1", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got valid=%b sum=%h cout=%b ovf=%b zero=%b, expected all 0",
               out_valid, out_sum, out_cout, out_ovf, out_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_release: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
    a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    e = model(a, b, c);
    drive_cycle(1'b1, a, b, c, 1'b1, acc, drn, ov, got);
    n_checks++;
    if (acc !== 1'b1 || drn !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_accept: got accept=%b drain=%b, expected 1/0", acc, drn);
    end
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, ov, got);
    n_checks++;
    if (drn !== 1'b1 || got !== e) begin
      n_fail++;
      $display("FAIL rstmid_item: got drain=%b res=%h, expected 1 res=%h", drn, got, e);
    end
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, ov, got);
    n_checks++;
    if (ov !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_stale: got out_valid=%b after single item, expected 0", ov);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_stream();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
